// File: rtl/alu_pkg.sv
// Shared definitions for the nibble ALU core and its 8-bit operation sequencer.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOTA = 4'd5;

  localparam int unsigned FLAG_CARRY = 0;
  localparam int unsigned FLAG_ZERO  = 1;
  localparam int unsigned FLAG_ERR   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  function automatic logic op_is_valid(input logic [3:0] op);
    return (op <= OP_NOTA);
  endfunction

  function automatic logic op_is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_timer.sv
// Per-pass down-counter: reloads at the start of each nibble pass and
// flags the pass's final cycle.
module alu_pass_timer #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic load,
  input  logic run,
  output logic last
);

  localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      if (load)
        cnt <= CW'(ALU_LAT - 1);
      else if (run && cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Runs 8-bit ALU operations as a low then high nibble pass over the 4-bit
// ALU core, chaining carry, behind command and response valid/ready handshakes.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  output logic       alu_cin,
  input  logic [3:0] alu_y,
  input  logic       alu_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_y,
  output logic [2:0] rsp_flags
);

  state_t     state;
  logic [3:0] op_q;
  logic [3:0] a_hi;
  logic [3:0] b_hi;
  logic [3:0] y_lo;
  logic [7:0] b_eff;
  logic [7:0] y_full;
  logic       last;
  logic       load;
  logic       accept;

  // rst_n gates ready so no command can be seen as accepted while in reset
  assign cmd_ready = rst_n & ena & (state == ST_IDLE);
  assign rsp_valid = (state == ST_RSP);
  assign accept    = cmd_valid & cmd_ready;
  assign b_eff     = (cmd_op == OP_SUB) ? ~cmd_b : cmd_b;
  assign y_full    = {alu_y, y_lo};
  assign load      = (accept && op_is_valid(cmd_op)) || (state == ST_LO && last);

  alu_pass_timer #(.ALU_LAT(ALU_LAT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .load  (load),
    .run   ((state == ST_LO) || (state == ST_HI)),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      a_hi      <= '0;
      b_hi      <= '0;
      y_lo      <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_cin   <= 1'b0;
      rsp_y     <= '0;
      rsp_flags <= '0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= cmd_op;
            a_hi <= cmd_a[7:4];
            b_hi <= b_eff[7:4];
            if (op_is_valid(cmd_op)) begin
              state   <= ST_LO;
              alu_a   <= cmd_a[3:0];
              alu_b   <= b_eff[3:0];
              alu_op  <= cmd_op;
              alu_cin <= (cmd_op == OP_SUB);
            end else begin
              state     <= ST_RSP;
              rsp_y     <= '0;
              rsp_flags <= 3'b100;
            end
          end
        end
        ST_LO: begin
          if (last) begin
            state   <= ST_HI;
            y_lo    <= alu_y;
            alu_a   <= a_hi;
            alu_b   <= b_hi;
            // alu_cin doubles as the inter-pass carry register
            alu_cin <= op_is_arith(op_q) & alu_cout;
          end
        end
        ST_HI: begin
          if (last) begin
            state                <= ST_RSP;
            rsp_y                <= y_full;
            rsp_flags[FLAG_ERR]   <= 1'b0;
            rsp_flags[FLAG_ZERO]  <= (y_full == 8'h00);
            rsp_flags[FLAG_CARRY] <= op_is_arith(op_q) & alu_cout;
          end
        end
        ST_RSP: begin
          if (rsp_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized and directed bench for alu_op_sequencer with a nibble ALU model.
module tb_alu_op_sequencer;

  localparam int unsigned LAT = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_op;
  logic       alu_cin;
  logic [3:0] alu_y;
  logic       alu_cout;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_y;
  logic [2:0] rsp_flags;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]  obs_y;
  logic [2:0]  obs_flags;
  int unsigned lat;
  logic [3:0]  lo_a, lo_b, lo_op;
  logic        lo_cin, hi_cin;

  always #5 clk = ~clk;

  alu_op_sequencer #(.ALU_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_cin   (alu_cin),
    .alu_y     (alu_y),
    .alu_cout  (alu_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_flags (rsp_flags)
  );

  // Nibble ALU core model (single-cycle, SUB expects B already inverted)
  logic [4:0] alu_s;
  always_comb begin
    alu_s = '0;
    case (alu_op)
      4'd0, 4'd1: alu_s = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
      4'd2:       alu_s = {1'b0, alu_a & alu_b};
      4'd3:       alu_s = {1'b0, alu_a | alu_b};
      4'd4:       alu_s = {1'b0, alu_a ^ alu_b};
      4'd5:       alu_s = {1'b0, ~alu_a};
      default:    alu_s = '0;
    endcase
  end
  assign alu_y    = alu_s[3:0];
  assign alu_cout = alu_s[4];

  // 8-bit reference: {err, zero, carry, y}
  function automatic logic [10:0] ref_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] y;
    logic       c;
    c = 1'b0;
    y = 8'h00;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; y = s[7:0]; c = s[8]; end
      4'd1: begin y = a - b; c = (a >= b); end
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      4'd5: y = ~a;
      default: return {3'b100, 8'h00};
    endcase
    return {1'b0, (y == 8'h00), c, y};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int unsigned gap, input int unsigned bp);
    logic [10:0] exp;
    int unsigned n;
    exp = ref_model(op, a, b);
    rsp_ready = (bp == 0);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("accept_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 4'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
    lo_a = alu_a; lo_b = alu_b; lo_op = alu_op; lo_cin = alu_cin;
    hi_cin = 1'b0;
    lat = 1;
    if (gap > 0) begin
      ena = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
      ena = 1'b1;
      lat += gap;
    end
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) hi_cin = alu_cin;
    end
    obs_y = rsp_y;
    obs_flags = rsp_flags;
    check("latency", lat, (exp[10] ? 32'd1 : 32'd1 + 32'd2 * LAT) + gap);
    check("rsp_y", {24'b0, rsp_y}, {24'b0, exp[7:0]});
    check("rsp_flags", {29'b0, rsp_flags}, {29'b0, exp[10:8]});
    for (int i = 0; i < int'(bp); i++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_y", {24'b0, rsp_y}, {24'b0, exp[7:0]});
      check("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("done_valid", {31'b0, rsp_valid}, 32'd0);
    check("done_cmd_ready", {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = '0; cmd_a = '0; cmd_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp", {21'b0, rsp_flags, rsp_y}, 32'd0);
    check("rst_alu", {19'b0, alu_a, alu_b, alu_op, alu_cin}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(4'd0, 8'h3A, 8'hC9, 0, 0);
    check("add_y", {24'b0, obs_y}, 32'h03);
    check("add_flags", {29'b0, obs_flags}, 32'b001);
    check("add_lo_cin", {31'b0, lo_cin}, 32'd0);
    check("add_hi_cin", {31'b0, hi_cin}, 32'd1);

    run_op(4'd1, 8'h50, 8'h51, 0, 0);
    check("sub_y", {24'b0, obs_y}, 32'hFF);
    check("sub_flags", {29'b0, obs_flags}, 32'b000);
    check("sub_lo_b", {28'b0, lo_b}, 32'hE);
    check("sub_lo_cin", {31'b0, lo_cin}, 32'd1);

    run_op(4'd2, 8'hF0, 8'h0F, 0, 0);
    check("and_y", {24'b0, obs_y}, 32'h00);
    check("and_flags", {29'b0, obs_flags}, 32'b010);
    run_op(4'd3, 8'hF0, 8'h0F, 0, 0);
    check("or_y", {24'b0, obs_y}, 32'hFF);
    check("or_flags", {29'b0, obs_flags}, 32'b000);

    // invalid op must not touch the ALU lines left by the OR high pass
    run_op(4'd9, 8'h12, 8'h34, 0, 0);
    check("inv_flags", {29'b0, obs_flags}, 32'b100);
    check("inv_alu_op", {28'b0, lo_op}, 32'd3);
    check("inv_alu_a", {28'b0, lo_a}, 32'hF);

    run_op(4'd4, 8'hAA, 8'h55, 0, 5);
    check("xor_y", {24'b0, obs_y}, 32'hFF);

    run_op(4'd0, 8'h27, 8'h19, 3, 0);
    check("ena_lat", lat, 32'd6);

    // reset during the high pass of 0xFF + 0x01
    cmd_op = 4'd0; cmd_a = 8'hFF; cmd_b = 8'h01; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_hi_a", {28'b0, alu_a}, 32'hF);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_rsp", {21'b0, rsp_flags, rsp_y}, 32'd0);
    check("mid_rst_alu", {19'b0, alu_a, alu_b, alu_op, alu_cin}, 32'd0);
    check("mid_rst_ready", {31'b0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    run_op(4'd0, 8'h01, 8'h01, 0, 0);
    check("post_rst_y", {24'b0, obs_y}, 32'h02);
    check("post_rst_flags", {29'b0, obs_flags}, 32'b000);

    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
